// File: rtl/mul_mdc_addr_gen.sv
// -----------------------------------------------------------------------------
// mul_mdc_addr_gen
//
// Per-stream address generator for the mul_mdc HWPE. A start pulse captures
// one job's configuration. The block then emits trans_size word addresses
// over a valid/ready handshake, one per accepted cycle. The address walk is
//   addr = base + feat_off + line_off + word_idx*step
// and it is built incrementally from running offsets, so only adders are used.
//
// Handshake: addr_o is offered while addr_valid_o is high. A transfer happens
// on every rising edge where addr_valid_o && addr_ready_i. addr_valid_o never
// drops while the address is unaccepted, and addr_o stays stable until then.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           synchronous soft clear, returns to IDLE without done_o
//   start_i           job start pulse, samples every cfg input (IDLE only)
//   base_addr_i .. loop_outer_i   job configuration
//   addr_o/addr_valid_o/addr_ready_i   address stream
//   busy_o            job in progress (RUN or DONE)
//   done_o            one-cycle pulse after the last address is accepted
//   state_o           debug view of the FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module mul_mdc_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [31:0]           trans_size_i,
  input  logic [CNT_WIDTH-1:0]  line_stride_i,
  input  logic [CNT_WIDTH-1:0]  line_length_i,
  input  logic [CNT_WIDTH-1:0]  feat_stride_i,
  input  logic [CNT_WIDTH-1:0]  feat_length_i,
  input  logic [CNT_WIDTH-1:0]  feat_roll_i,
  input  logic [CNT_WIDTH-1:0]  step_i,
  input  logic                  loop_outer_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured configuration. Lengths are stored as "limit - 1" with a zero
  // length already folded to a limit of 1.
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           trans_q, trans_d;
  logic [CNT_WIDTH-1:0]  line_stride_q, line_stride_d;
  logic [CNT_WIDTH-1:0]  feat_stride_q, feat_stride_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic [CNT_WIDTH-1:0]  llen_m1_q, llen_m1_d;
  logic [CNT_WIDTH-1:0]  flen_m1_q, flen_m1_d;
  logic [CNT_WIDTH-1:0]  froll_m1_q, froll_m1_d;
  logic                  outer_q, outer_d;

  // Loop counters and running offsets.
  logic [CNT_WIDTH-1:0]  word_idx_q, word_idx_d;
  logic [CNT_WIDTH-1:0]  line_idx_q, line_idx_d;
  logic [CNT_WIDTH-1:0]  feat_idx_q, feat_idx_d;
  logic [31:0]           emitted_q, emitted_d;
  logic [ADDR_WIDTH-1:0] word_off_q, word_off_d;
  logic [ADDR_WIDTH-1:0] line_off_q, line_off_d;
  logic [ADDR_WIDTH-1:0] feat_off_q, feat_off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic zero_cnt;

  function automatic logic [CNT_WIDTH-1:0] limit_m1(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    trans_d       = trans_q;
    line_stride_d = line_stride_q;
    feat_stride_d = feat_stride_q;
    step_d        = step_q;
    llen_m1_d     = llen_m1_q;
    flen_m1_d     = flen_m1_q;
    froll_m1_d    = froll_m1_q;
    outer_d       = outer_q;
    word_idx_d    = word_idx_q;
    line_idx_d    = line_idx_q;
    feat_idx_d    = feat_idx_q;
    emitted_d     = emitted_q;
    word_off_d    = word_off_q;
    line_off_d    = line_off_q;
    feat_off_d    = feat_off_q;
    addr_d        = addr_q;
    zero_cnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d        = base_addr_i;
          trans_d       = trans_size_i;
          line_stride_d = line_stride_i;
          feat_stride_d = feat_stride_i;
          step_d        = step_i;
          llen_m1_d     = limit_m1(line_length_i);
          flen_m1_d     = limit_m1(feat_length_i);
          froll_m1_d    = limit_m1(feat_roll_i);
          outer_d       = loop_outer_i;
          zero_cnt      = 1'b1;
          if (trans_size_i == 32'd0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            addr_d  = base_addr_i;
          end
        end
      end

      RUN: begin
        // addr_valid_o is high throughout RUN, so ready alone marks a transfer.
        if (addr_ready_i) begin
          emitted_d  = emitted_q + 32'd1;
          word_idx_d = word_idx_q + 1'b1;
          word_off_d = word_off_q + ADDR_WIDTH'(step_q);
          if (word_idx_q == llen_m1_q) begin
            word_idx_d = '0;
            word_off_d = '0;
            line_idx_d = line_idx_q + 1'b1;
            line_off_d = line_off_q + ADDR_WIDTH'(line_stride_q);
            if (outer_q && (line_idx_q == flen_m1_q)) begin
              line_idx_d = '0;
              line_off_d = '0;
              feat_idx_d = feat_idx_q + 1'b1;
              feat_off_d = feat_off_q + ADDR_WIDTH'(feat_stride_q);
              if (feat_idx_q == froll_m1_q) begin
                feat_idx_d = '0;
                feat_off_d = '0;
              end
            end
          end
          if (emitted_q == trans_q - 32'd1) begin
            state_d = DONE;
            addr_d  = '0;
          end else begin
            addr_d = base_q + feat_off_d + line_off_d + word_off_d;
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        zero_cnt = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        zero_cnt = 1'b1;
      end
    endcase

    // Soft clear wins over start and over a transfer in the same cycle.
    if (clear_i) begin
      state_d  = IDLE;
      zero_cnt = 1'b1;
      addr_d   = '0;
    end

    if (zero_cnt) begin
      word_idx_d = '0;
      line_idx_d = '0;
      feat_idx_d = '0;
      emitted_d  = '0;
      word_off_d = '0;
      line_off_d = '0;
      feat_off_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      base_q        <= '0;
      trans_q       <= '0;
      line_stride_q <= '0;
      feat_stride_q <= '0;
      step_q        <= '0;
      llen_m1_q     <= '0;
      flen_m1_q     <= '0;
      froll_m1_q    <= '0;
      outer_q       <= 1'b0;
      word_idx_q    <= '0;
      line_idx_q    <= '0;
      feat_idx_q    <= '0;
      emitted_q     <= '0;
      word_off_q    <= '0;
      line_off_q    <= '0;
      feat_off_q    <= '0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      trans_q       <= trans_d;
      line_stride_q <= line_stride_d;
      feat_stride_q <= feat_stride_d;
      step_q        <= step_d;
      llen_m1_q     <= llen_m1_d;
      flen_m1_q     <= flen_m1_d;
      froll_m1_q    <= froll_m1_d;
      outer_q       <= outer_d;
      word_idx_q    <= word_idx_d;
      line_idx_q    <= line_idx_d;
      feat_idx_q    <= feat_idx_d;
      emitted_q     <= emitted_d;
      word_off_q    <= word_off_d;
      line_off_q    <= line_off_d;
      feat_off_q    <= feat_off_d;
      addr_q        <= addr_d;
    end
  end

  // Every output is a register or a decode of the state register only.
  assign addr_o       = addr_q;
  assign addr_valid_o = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_mul_mdc_addr_gen.sv
module tb_mul_mdc_addr_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [31:0]   trans_size_i = '0;
  logic [CW-1:0] line_stride_i = '0;
  logic [CW-1:0] line_length_i = '0;
  logic [CW-1:0] feat_stride_i = '0;
  logic [CW-1:0] feat_length_i = '0;
  logic [CW-1:0] feat_roll_i = '0;
  logic [CW-1:0] step_i = '0;
  logic          loop_outer_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic          addr_valid_o;
  logic          addr_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    state_o;

  mul_mdc_addr_gen #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .trans_size_i  (trans_size_i),
    .line_stride_i (line_stride_i),
    .line_length_i (line_length_i),
    .feat_stride_i (feat_stride_i),
    .feat_length_i (feat_length_i),
    .feat_roll_i   (feat_roll_i),
    .step_i        (step_i),
    .loop_outer_i  (loop_outer_i),
    .addr_o        (addr_o),
    .addr_valid_o  (addr_valid_o),
    .addr_ready_i  (addr_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- scoreboard
  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Job configuration as seen by the model.
  logic [AW-1:0] c_base;
  logic [31:0]   c_trans;
  logic [CW-1:0] c_ll, c_step, c_ls, c_fl, c_fs, c_fr;
  logic          c_outer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: closed-form index arithmetic for the k-th address.
  function automatic void build_expected();
    longint unsigned l, f, r, w, lines, li, fi, a;
    exp_q.delete();
    l = (c_ll == 0) ? 1 : longint'(c_ll);
    f = (c_fl == 0) ? 1 : longint'(c_fl);
    r = (c_fr == 0) ? 1 : longint'(c_fr);
    for (longint unsigned k = 0; k < longint'(c_trans); k++) begin
      w     = k % l;
      lines = k / l;
      if (c_outer) begin
        li = lines % f;
        fi = (lines / f) % r;
        a  = longint'(c_base) + fi * c_fs + li * c_ls + w * c_step;
      end else begin
        a  = longint'(c_base) + lines * c_ls + w * c_step;
      end
      exp_q.push_back(a[AW-1:0]);
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic set_cfg(input logic [AW-1:0] base, input logic [31:0] trans,
                         input logic [CW-1:0] ll, input logic [CW-1:0] step,
                         input logic [CW-1:0] ls, input logic [CW-1:0] fl,
                         input logic [CW-1:0] fs, input logic [CW-1:0] fr,
                         input logic outer);
    c_base = base; c_trans = trans; c_ll = ll; c_step = step; c_ls = ls;
    c_fl = fl; c_fs = fs; c_fr = fr; c_outer = outer;
  endtask

  task automatic drive_cfg();
    base_addr_i   = c_base;
    trans_size_i  = c_trans;
    line_length_i = c_ll;
    step_i        = c_step;
    line_stride_i = c_ls;
    feat_length_i = c_fl;
    feat_stride_i = c_fs;
    feat_roll_i   = c_fr;
    loop_outer_i  = c_outer;
  endtask

  // Config inputs get garbage after the start edge; the job must not care.
  task automatic scramble_cfg();
    base_addr_i   = $urandom;
    trans_size_i  = $urandom_range(0, 50);
    line_length_i = CW'($urandom);
    step_i        = CW'($urandom);
    line_stride_i = CW'($urandom);
    feat_length_i = CW'($urandom);
    feat_stride_i = CW'($urandom);
    feat_roll_i   = CW'($urandom);
    loop_outer_i  = 1'($urandom);
  endtask

  function automatic logic pick_ready(input bit rand_ready);
    if (!rand_ready) return 1'b1;
    return ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
  endfunction

  // Called between clock edges. Starts the job, follows the stream against
  // the model, then checks the done pulse and the return to idle.
  task automatic run_job(input string name, input bit rand_ready, input bit poke_start);
    int cyc;
    int budget;
    build_expected();
    budget = int'(c_trans) * 20 + 20;
    drive_cfg();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    scramble_cfg();
    addr_ready_i = pick_ready(rand_ready);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk_i);
      chk({name, " valid"}, addr_valid_o, 1'b1);
      chk({name, " busy"}, busy_o, 1'b1);
      chk({name, " no_done"}, done_o, 1'b0);
      if (addr_valid_o) chk({name, " addr"}, addr_o, exp_q[0]);
      if (addr_valid_o && addr_ready_i) void'(exp_q.pop_front());
      @(posedge clk_i); #1;
      addr_ready_i = pick_ready(rand_ready);
      start_i = poke_start && (cyc == 2);
      cyc++;
    end
    start_i = 1'b0;
    if (exp_q.size() != 0) begin
      chk({name, " timeout_left"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk_i);
    chk({name, " done"}, done_o, 1'b1);
    chk({name, " done_valid"}, addr_valid_o, 1'b0);
    chk({name, " done_busy"}, busy_o, 1'b1);
    @(negedge clk_i);
    chk({name, " idle_done"}, done_o, 1'b0);
    chk({name, " idle_busy"}, busy_o, 1'b0);
    chk({name, " idle_valid"}, addr_valid_o, 1'b0);
    chk({name, " idle_addr"}, addr_o, 0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst addr", addr_o, 0);
    chk("rst valid", addr_valid_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst state", state_o, 2'd0);

    // Linear run, ready held high.
    set_cfg(32'h1000, 8, 4, 4, 16, 0, 0, 0, 1'b0);
    run_job("linear", 1'b0, 1'b0);
    // Same job under random backpressure, plus a start poke mid-job.
    run_job("backpressure", 1'b1, 1'b1);
    // Outer loop with roll.
    set_cfg(32'h0, 12, 2, 4, 16'h100, 2, 16'h1000, 2, 1'b1);
    run_job("outer_roll", 1'b0, 1'b0);
    // Zero transactions: done one cycle after start, never valid.
    set_cfg(32'h4000, 0, 4, 4, 16, 0, 0, 0, 1'b0);
    run_job("trans0", 1'b1, 1'b0);
    // Zero line length behaves as one word per line.
    set_cfg(32'h3000, 3, 0, 4, 8, 0, 0, 0, 1'b0);
    run_job("llen0", 1'b0, 1'b0);
    // Address wrap-around.
    set_cfg(32'hFFFF_FFFC, 2, 4, 4, 16, 0, 0, 0, 1'b0);
    run_job("wrap", 1'b0, 1'b0);

    // Clear mid-job, together with a transfer and a start request.
    set_cfg(32'h2000, 20, 4, 4, 16, 0, 0, 0, 1'b0);
    drive_cfg();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    addr_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    start_i = 1'b1;
    base_addr_i = 32'h7777_0000;
    @(negedge clk_i);
    chk("clear pre_valid", addr_valid_o, 1'b1);
    chk("clear pre_addr", addr_o, 32'h200C);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("clear valid", addr_valid_o, 1'b0);
    chk("clear busy", busy_o, 1'b0);
    chk("clear done", done_o, 1'b0);
    chk("clear addr", addr_o, 0);
    @(negedge clk_i);
    chk("clear stay_idle", busy_o, 1'b0);
    chk("clear no_done", done_o, 1'b0);
    set_cfg(32'h5000, 6, 3, 8, 32, 0, 0, 0, 1'b0);
    run_job("after_clear", 1'b1, 1'b0);

    // Asynchronous reset in the middle of a transfer.
    set_cfg(32'h6000, 10, 4, 4, 16, 0, 0, 0, 1'b0);
    drive_cfg();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    addr_ready_i = 1'b1;
    @(posedge clk_i); #2;
    chk("rst_mid pre_valid", addr_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid addr", addr_o, 0);
    chk("rst_mid valid", addr_valid_o, 1'b0);
    chk("rst_mid busy", busy_o, 1'b0);
    chk("rst_mid done", done_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid state", state_o, 2'd0);

    // Randomized jobs against the model.
    for (int j = 0; j < 12; j++) begin
      set_cfg($urandom, $urandom_range(0, 30), CW'($urandom_range(0, 5)),
              CW'($urandom), CW'($urandom), CW'($urandom_range(0, 4)),
              CW'($urandom), CW'($urandom_range(0, 3)), 1'($urandom));
      run_job($sformatf("rand%0d", j), 1'b1, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_mdc_addr_gen.md
# mul_mdc_addr_gen

Address generator for the mul_mdc HWPE, placed directly downstream of the controller's per-stream configuration registers and upstream of the TCDM source/sink streamer. At `start_i` it captures one stream's job parameters: base address, transaction count, line/feature strides and lengths, step, roll and outer-loop mode. It then emits exactly `trans_size` word addresses over a valid/ready handshake, one per accepted cycle. It asserts a one-cycle `done_o` when the last address has been accepted. One instance serves each stream (a, b, c, d).

## Interface
Parameters:
- ADDR_WIDTH, 32, width of generated address and base address
- CNT_WIDTH, 16, width of length/stride/step/roll fields and internal loop counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous soft clear (driven from controller clear)
- start_i  in  1  one-cycle job start pulse; samples all cfg inputs
- base_addr_i  in  ADDR_WIDTH  stream base address
- trans_size_i  in  32  total addresses to emit
- line_stride_i  in  CNT_WIDTH  byte offset between consecutive lines
- line_length_i  in  CNT_WIDTH  words per line
- feat_stride_i  in  CNT_WIDTH  byte offset between consecutive features
- feat_length_i  in  CNT_WIDTH  lines per feature (outer mode only)
- feat_roll_i  in  CNT_WIDTH  features before feature offset returns to 0
- step_i  in  CNT_WIDTH  byte offset between consecutive words in a line
- loop_outer_i  in  1  0: lines only; 1: lines nested in features
- addr_o  out  ADDR_WIDTH  generated address
- addr_valid_o  out  1  addr_o valid
- addr_ready_i  in  1  consumer accepts addr_o
- busy_o  out  1  job in progress (RUN or DONE)
- done_o  out  1  one-cycle pulse, last address accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - outputs are 0.
  - `start_i` latches all cfg inputs.
  - `trans_size_i == 0` -> DONE.
  - otherwise -> RUN, with counters zeroed and `addr_o = base`.
- Address formula: `addr = base + feat_off + line_off + word_idx*step`, computed incrementally by adders only (no multiplier).
- Addition is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Strides and step are unsigned and zero-extended.
- Advance occurs only on handshake (`addr_valid_o && addr_ready_i`):
  - `word_idx++`. At `word_idx == line_length-1`: `word_idx = 0`, `line_off += line_stride`, `line_idx++`.
  - `loop_outer = 1` and line wrap at `line_idx == feat_length-1`: `line_idx = 0`, `line_off = 0`, `feat_idx++`, `feat_off += feat_stride`.
  - If additionally `feat_idx == feat_roll-1`: `feat_idx = 0`, `feat_off = 0`.
  - `loop_outer = 0`: `feat_length`, `feat_roll` and `feat_stride` are ignored; `line_off` accumulates without limit.
  - `emitted++`. When `emitted == trans_size-1` at the handshake -> DONE.
- A zero in `line_length`, `feat_length` or `feat_roll` is treated as 1.
- DONE: `done_o = 1` for exactly one cycle, `addr_valid_o = 0`; next state IDLE.
- `start_i` outside IDLE is ignored; cfg inputs are not re-sampled.
- `clear_i`:
  - From any state -> IDLE next cycle.
  - Counters and offsets are zeroed; `done_o` is not pulsed.
  - `clear_i` takes priority over `start_i` and over a simultaneous handshake.
- `rst_i`: immediate return to IDLE; all registers are 0.

## Timing
- Reset values: `addr_o = 0`, `addr_valid_o = 0`, `busy_o = 0`, `done_o = 0`. All state and counters are 0.
- All outputs are registered; there is no combinational path from `addr_ready_i` to any output.
- `start_i` at edge t:
  - `addr_valid_o = 1` and `addr_o = base` from cycle t+1.
  - `busy_o = 1` from cycle t+1.
- Throughput: one address per cycle while `addr_ready_i` is held high.
- Handshake rules:
  - Once `addr_valid_o` rises, it stays high and `addr_o` stays stable until accepted.
  - `addr_valid_o` never drops between addresses within a job.
- Last handshake at edge t:
  - Cycle t+1: `addr_valid_o = 0`, `done_o = 1`, `busy_o = 1`.
  - Cycle t+2: IDLE, `busy_o = 0`.
- `trans_size = 0`: `start_i` at t -> `done_o` at t+1, no valid ever asserted.
- Back-to-back jobs: a new `start_i` is accepted from the first IDLE cycle (t+2).

## Test plan
- Linear run:
  - Stimulus: base `0x1000`, `trans_size` 8, `line_length` 4, `step` 4, `line_stride` 16, `loop_outer` 0, ready held high.
  - Response: addresses `0x1000`, `1004`, `1008`, `100C`, `1010` ... `101C` on 8 consecutive cycles; `done_o` one cycle after the last.
- Outer loop with roll:
  - Stimulus: base 0, `trans_size` 12, `line_length` 2, `step` 4, `line_stride` 0x100, `feat_length` 2, `feat_stride` 0x1000, `feat_roll` 2, `loop_outer` 1.
  - Response: `0,4,100,104, 1000,1004,1100,1104, 0,4,100,104`.
- Backpressure:
  - Stimulus: linear job, `addr_ready_i` toggled randomly.
  - Response: `addr_o` is stable while valid and not ready; the same sequence as the ready-high run; no drops or duplicates.
- Degenerate config:
  - Stimulus: `trans_size` 0.
  - Response: `done_o` at t+1, `addr_valid_o` never high.
  - Stimulus: `line_length` 0, `step` 4, `line_stride` 8, `trans_size` 3.
  - Response: `base`, `base+8`, `base+16`.
- Abort and wrap:
  - `clear_i` mid-job -> IDLE next cycle, no `done_o`, next `start_i` restarts from the new base.
  - `rst_i` asserted mid-handshake -> all outputs 0 immediately.
  - Base `0xFFFFFFFC`, `step` 4, `trans_size` 2 -> `0xFFFFFFFC`, `0x00000000`.
